// File: rtl/serial_rx.sv
// UART 8N1 receiver: mid-bit sampling by clock counting, one-entry holding register
// with valid/ready handshake, and single-cycle framing-error and overrun pulses.
module serial_rx #(
  parameter int unsigned BAUD_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       ovr
);

  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned CW   = $clog2(BAUD_DIV);

  // Counter reload values: a count of N cycles reloads with N-1 and fires at zero.
  localparam logic [CW-1:0] HalfLoad = CW'(HALF - 1);
  localparam logic [CW-1:0] BaudLoad = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            stop_good;

  assign stop_good = (state == StStop) && (cnt == '0) && rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      ferr <= 1'b0;
      ovr  <= 1'b0;

      // A delivery may coincide with a drain; the drain then frees the slot for the new byte.
      if (stop_good) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (!rx) begin
            state <= StStart;
            cnt   <= HalfLoad;
          end
        end
        StStart: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx) begin
            state   <= StData;
            cnt     <= BaudLoad;
            bit_idx <= '0;
          end else begin
            state <= StIdle;
          end
        end
        StData: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[bit_idx] <= rx;
            cnt            <= BaudLoad;
            if (bit_idx == 3'd7) begin
              state <= StStop;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        StStop: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx) begin
            state <= StIdle;
          end else begin
            ferr  <= 1'b1;
            state <= StBreak;
          end
        end
        StBreak: begin
          if (rx) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
